// File: rtl/von_fetch_ctrl.sv
// Instruction-fetch sequencer: drives the PC register, the memory read handshake and the IR hand-off to execute.
// Define FETCH_TIMEOUT_EN to enable the memory-ack timeout and the sticky fault state.
module von_fetch_ctrl #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              run,
    input  logic [ADDR_W-1:0] pc_value,
    output logic              pc_load,
    output logic              pc_inc,
    output logic              pc_clear,
    output logic [ADDR_W-1:0] pc_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ir_load,
    output logic [DATA_W-1:0] ir_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    output logic              fault
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DRAIN,
        S_SETTLE,
        S_FAULT
    } state_t;

    state_t              state_q;
    logic                pc_load_q;
    logic                pc_inc_q;
    logic                pc_clear_q;
    logic [ADDR_W-1:0]   pc_data_q;
    logic                mem_req_q;
    logic                ir_load_q;
    logic [DATA_W-1:0]   ir_data_q;
    logic                instr_valid_q;
    logic                fault_q;
    logic                to_hit;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [CNT_W-1:0] to_cnt_q;
    logic [CNT_W-1:0] to_cnt_d;
    logic             waiting;

    // Counts consecutive un-acked cycles of one outstanding request, across a REQ->DRAIN move.
    assign waiting = ((state_q == S_REQ) || (state_q == S_DRAIN)) && !mem_ack;
    assign to_hit  = waiting && (to_cnt_q == CNT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        to_cnt_d = '0;
        if (waiting) begin
            to_cnt_d = to_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    // Without the timeout feature the request waits indefinitely.
    assign to_hit = (MEM_TIMEOUT < 0);
`endif

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q       <= S_INIT;
            pc_load_q     <= 1'b0;
            pc_inc_q      <= 1'b0;
            pc_clear_q    <= 1'b0;
            pc_data_q     <= '0;
            mem_req_q     <= 1'b0;
            ir_load_q     <= 1'b0;
            ir_data_q     <= '0;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            pc_load_q  <= 1'b0;
            pc_inc_q   <= 1'b0;
            pc_clear_q <= 1'b0;
            ir_load_q  <= 1'b0;
            case (state_q)
                S_INIT: begin
                    pc_clear_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
                S_IDLE: begin
                    if (br_valid) begin
                        pc_load_q <= 1'b1;
                        pc_data_q <= br_target;
                        state_q   <= S_SETTLE;
                    end else if (run) begin
                        mem_req_q <= 1'b1;
                        state_q   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (to_hit) begin
                        mem_req_q <= 1'b0;
                        fault_q   <= 1'b1;
                        state_q   <= S_FAULT;
                    end else if (br_valid) begin
                        // A branch always wins over returning data; an ack in the same cycle is discarded.
                        pc_load_q <= 1'b1;
                        pc_data_q <= br_target;
                        if (mem_ack) begin
                            mem_req_q <= 1'b0;
                            state_q   <= S_SETTLE;
                        end else begin
                            state_q <= S_DRAIN;
                        end
                    end else if (mem_ack) begin
                        ir_data_q     <= mem_rdata;
                        ir_load_q     <= 1'b1;
                        pc_inc_q      <= 1'b1;
                        instr_valid_q <= 1'b1;
                        mem_req_q     <= 1'b0;
                        state_q       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (br_valid) begin
                        pc_load_q     <= 1'b1;
                        pc_data_q     <= br_target;
                        instr_valid_q <= 1'b0;
                        state_q       <= S_SETTLE;
                    end else if (instr_ready) begin
                        instr_valid_q <= 1'b0;
                        mem_req_q     <= run;
                        state_q       <= run ? S_REQ : S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (to_hit) begin
                        mem_req_q <= 1'b0;
                        fault_q   <= 1'b1;
                        state_q   <= S_FAULT;
                    end else if (br_valid) begin
                        pc_load_q <= 1'b1;
                        pc_data_q <= br_target;
                        if (mem_ack) begin
                            mem_req_q <= 1'b0;
                            state_q   <= S_SETTLE;
                        end
                    end else if (mem_ack) begin
                        // Stale data from the redirected fetch is dropped; PC already holds the target.
                        mem_req_q <= run;
                        state_q   <= run ? S_REQ : S_IDLE;
                    end
                end
                S_SETTLE: begin
                    if (br_valid) begin
                        pc_load_q <= 1'b1;
                        pc_data_q <= br_target;
                    end else begin
                        mem_req_q <= run;
                        state_q   <= run ? S_REQ : S_IDLE;
                    end
                end
                S_FAULT: begin
                    state_q <= S_FAULT;
                end
                default: begin
                    state_q <= S_INIT;
                end
            endcase
        end
    end

    assign pc_load     = pc_load_q;
    assign pc_inc      = pc_inc_q;
    assign pc_clear    = pc_clear_q;
    assign pc_data     = pc_data_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_req_q ? pc_value : '0;
    assign ir_load     = ir_load_q;
    assign ir_data     = ir_data_q;
    assign instr_valid = instr_valid_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_von_fetch_ctrl.sv
// Scoreboard bench for von_fetch_ctrl: directed fetch/branch/stall/drain/reset scenarios against a PC register and memory model.
module tb_von_fetch_ctrl;

    logic       clk = 1'b0;
    logic       clear_n;
    logic       run;
    logic [3:0] pc_q = 4'd7;
    logic       pc_load;
    logic       pc_inc;
    logic       pc_clear;
    logic [3:0] pc_data;
    logic       mem_req;
    logic [3:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic       ir_load;
    logic [7:0] ir_data;
    logic       instr_valid;
    logic       instr_ready;
    logic       br_valid;
    logic [3:0] br_target;
    logic       fault;

    int checks = 0;
    int failures = 0;
    int pc_clear_cnt = 0;

    logic [3:0] exp_addr_q[$];
    logic [3:0] exp_inc_q[$];
    logic [3:0] exp_load_q[$];
    logic [7:0] exp_ir_q[$];

    von_fetch_ctrl #(.ADDR_W(4), .DATA_W(8), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .clear_n(clear_n), .run(run), .pc_value(pc_q),
        .pc_load(pc_load), .pc_inc(pc_inc), .pc_clear(pc_clear), .pc_data(pc_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ir_load(ir_load), .ir_data(ir_data), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .br_valid(br_valid), .br_target(br_target), .fault(fault)
    );

    always #5 clk = ~clk;

    // PC register the controller drives.
    always @(posedge clk) begin
        if (pc_clear)     pc_q <= 4'd0;
        else if (pc_load) pc_q <= pc_data;
        else if (pc_inc)  pc_q <= pc_q + 4'd1;
    end

    function automatic logic [7:0] mem_word(input logic [3:0] a);
        return {a, ~a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=%0h required=no_event", name, act);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (mem_req !== 1'b1 && n < 32) begin
            tick();
            n++;
        end
        check("wait_mem_req", 32'(mem_req), 32'd1);
    endtask

    task automatic do_fetch(input logic [3:0] a, input int dly);
        wait_req();
        exp_addr_q.push_back(a);
        exp_ir_q.push_back(mem_word(a));
        exp_inc_q.push_back(a);
        repeat (dly) tick();
        mem_ack   = 1'b1;
        mem_rdata = mem_word(mem_addr);
        tick();
        mem_ack   = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    always @(negedge clk) begin
        if (pc_clear) pc_clear_cnt++;
        if (pc_load || pc_inc || pc_clear)
            check("pc_pulse_onehot", 32'($countones({pc_load, pc_inc, pc_clear})), 32'd1);
        if (mem_req && mem_ack) begin
            if (exp_addr_q.size() == 0) unexpected("mem_addr_unexpected", 32'(mem_addr));
            else check("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
        end
        if (ir_load) begin
            if (exp_ir_q.size() == 0) unexpected("ir_load_unexpected", 32'(ir_data));
            else check("ir_data", 32'(ir_data), 32'(exp_ir_q.pop_front()));
        end
        if (pc_inc) begin
            if (exp_inc_q.size() == 0) unexpected("pc_inc_unexpected", 32'(pc_q));
            else check("pc_inc_from", 32'(pc_q), 32'(exp_inc_q.pop_front()));
        end
        if (pc_load) begin
            check("pc_load_valid_low", 32'(instr_valid), 32'd0);
            if (exp_load_q.size() == 0) unexpected("pc_load_unexpected", 32'(pc_data));
            else check("pc_data", 32'(pc_data), 32'(exp_load_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_n = 1'b0; run = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
        instr_ready = 1'b1; br_valid = 1'b0; br_target = 4'd0;
        repeat (3) tick();
        check("reset_outputs", 32'({pc_load, pc_inc, pc_clear, pc_data, mem_req, mem_addr,
                                    ir_load, ir_data, instr_valid, fault}), 32'd0);

        // Sequential fetches from 0 after reset
        clear_n = 1'b1;
        run     = 1'b1;
        do_fetch(4'd0, 1);
        do_fetch(4'd1, 1);
        do_fetch(4'd2, 1);
        run = 1'b0;
        tick();
        tick();
        check("idle_no_req", 32'(mem_req), 32'd0);
        check("pc_clear_once", 32'(pc_clear_cnt), 32'd1);

        // Branch from IDLE to 15, then fetch 15 and wrap to 0
        br_valid = 1'b1; br_target = 4'd15;
        exp_load_q.push_back(4'd15);
        tick();
        br_valid = 1'b0;
        run = 1'b1;
        do_fetch(4'd15, 1);
        do_fetch(4'd0, 1);
        tick();

        // Execute stalls for 5 cycles
        instr_ready = 1'b0;
        do_fetch(4'd1, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid_held", 32'(instr_valid), 32'd1);
            check("stall_no_req", 32'(mem_req), 32'd0);
            check("stall_ir_stable", 32'(ir_data), 32'(mem_word(4'd1)));
        end
        instr_ready = 1'b1;
        tick();
        check("handoff_valid_drop", 32'(instr_valid), 32'd0);
        check("handoff_next_req", 32'(mem_req), 32'd1);

        // Branch to 9 in the same cycle as mem_ack
        wait_req();
        exp_addr_q.push_back(4'd2);
        exp_load_q.push_back(4'd9);
        mem_ack = 1'b1; mem_rdata = mem_word(mem_addr);
        br_valid = 1'b1; br_target = 4'd9;
        tick();
        mem_ack = 1'b0; br_valid = 1'b0;
        check("br_ack_req_drop", 32'(mem_req), 32'd0);
        do_fetch(4'd9, 1);

        // Branch to 5 during an outstanding request; ack arrives 3 cycles later
        wait_req();
        check("req_addr_10", 32'(mem_addr), 32'd10);
        tick();
        br_valid = 1'b1; br_target = 4'd5;
        exp_load_q.push_back(4'd5);
        tick();
        br_valid = 1'b0;
        check("drain_req_held", 32'(mem_req), 32'd1);
        tick();
        tick();
        exp_addr_q.push_back(4'd5);
        mem_ack = 1'b1; mem_rdata = 8'hEE;
        tick();
        mem_ack = 1'b0;
        do_fetch(4'd5, 1);

        // Reset asserted mid-request
        wait_req();
        tick();
        clear_n = 1'b0;
        tick();
        check("reset_mid_req", 32'({mem_req, instr_valid, pc_load, pc_inc, ir_load, fault}), 32'd0);
        clear_n = 1'b1;
        tick();
        tick();
        check("pc_clear_after_reset", 32'(pc_clear_cnt), 32'd2);

`ifdef FETCH_TIMEOUT_EN
        begin
            int n = 0;
            wait_req();
            while (fault !== 1'b1 && n < 40) begin
                tick();
                n++;
            end
            check("timeout_cycles", 32'(n), 32'd15);
            check("timeout_fault", 32'(fault), 32'd1);
            check("timeout_req_drop", 32'(mem_req), 32'd0);
            clear_n = 1'b0;
            tick();
            check("fault_cleared", 32'(fault), 32'd0);
            clear_n = 1'b1;
        end
`endif

        run = 1'b0;
        repeat (3) tick();
        check("scoreboard_empty",
              32'(exp_addr_q.size() + exp_inc_q.size() + exp_load_q.size() + exp_ir_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
